receiver_controller: RTL and testbench
======================================

RECEIVER_CONTROLLER -- requirements
Module: receiver_controller

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO depth in bytes; fixed at 4 in this revision.
REQ-003 clk  input  1  system clock; all logic rises on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ser_in  input  1  UART serial line; idle high; asynchronous to clk.
REQ-006 S  input  2  baud select: 00=9600, 01=19200, 10=57600, 11=115200.
REQ-007 rd_en  input  1  pop request for the FIFO head byte.
REQ-008 clr_err  input  1  one-cycle pulse that clears frame_err and overrun.
REQ-009 data_out  output  8  FIFO head byte, first-word fall-through; valid while rx_valid=1.
REQ-010 rx_valid  output  1  FIFO not empty.
REQ-011 rx_count  output  3  FIFO occupancy, 0..4.
REQ-012 busy  output  1  high when the FSM is in any state other than IDLE.
REQ-013 frame_err  output  1  sticky framing-error flag.
REQ-014 overrun  output  1  sticky FIFO-overrun flag.

Function
REQ-015 ser_in SHALL pass through a 2-flop synchronizer (both flops reset to 1) before use; rx denotes the synchronized bit.
REQ-016 Tick generator SHALL pulse one clk every DIV clocks, with DIV = CLK_HZ/(baud*16) truncated and minimum 1.
REQ-017 Tick divider SHALL restart from zero when the FSM leaves IDLE.
REQ-018 S SHALL be latched only on the IDLE->START transition; changes to S mid-frame SHALL have no effect on the current frame.
REQ-019 FSM states SHALL be IDLE, START, DATA, STOP and BREAK; reset state is IDLE.
REQ-020 IDLE->START SHALL occur on the first clk in which rx=0; the sample counter SHALL be cleared to 0.
REQ-021 START: on the 8th tick (mid-bit), rx=0 SHALL go to DATA with bit index 0; rx=1 SHALL return to IDLE (glitch reject, no flags).
REQ-022 DATA: every 16th tick SHALL shift rx into the shift register LSB-first; after bit 7 the FSM SHALL go to STOP.
REQ-023 STOP: on the 16th tick, rx=1 SHALL push the byte to the FIFO and go to IDLE, i.e. mid-stop-bit.
REQ-024 STOP: on the 16th tick, rx=0 SHALL discard the byte, set frame_err, and go to BREAK.
REQ-025 BREAK SHALL go to IDLE on the first clk in which rx=1.
REQ-026 A FIFO push SHALL make the byte visible at data_out/rx_valid on the clk after the push edge.
REQ-027 rd_en with rx_valid=1 SHALL pop the head; rd_en with rx_valid=0 SHALL be ignored.
REQ-028 A push to a full FIFO with no pop in the same cycle SHALL drop the new byte, set overrun, and leave contents unchanged.
REQ-029 A push and a pop in the same cycle SHALL both occur: rx_count is unchanged and overrun is not set, including when full.
REQ-030 Read and write pointers SHALL be 2-bit and wrap 3->0.
REQ-031 clr_err SHALL clear frame_err and overrun; a set event in the same cycle SHALL win (flag stays 1).
REQ-032 data_out SHALL hold its last value when the FIFO is empty.

Reset
REQ-033 On reset assertion, the following SHALL take effect immediately:
- FSM to IDLE; tick counter, sample counter, bit index and shift register to 0.
- FIFO pointers to 0 and contents to 0.
- Synchronizer flops to 1.
- Outputs: data_out=8'h00, rx_valid=0, rx_count=0, busy=0, frame_err=0, overrun=0.
REQ-034 Reset mid-frame SHALL discard the partial byte; after release, the FSM SHALL wait for a new falling edge of rx.

Verification (CLK_HZ=1_843_200 gives DIV=12/6/2/1 for S=00/01/10/11)
REQ-035 S=11, send 0xA5 (16 clk/bit) -> rx_valid=1, data_out=8'hA5, rx_count=1, frame_err=0.
REQ-036 S=11, 6-clk low pulse on idle line -> START returns to IDLE; rx_valid=0, no flags set.
REQ-037 S=01, send 0x3C with stop bit forced 0, then line high -> frame_err=1, rx_count=0; clr_err -> frame_err=0.
REQ-038 S=11, send 0x01..0x05 with no reads -> rx_count=4, overrun=1; pops return 0x01,0x02,0x03,0x04.
REQ-039 FIFO full, rd_en asserted on the push cycle of byte 0x55 -> rx_count stays 4, overrun=0, last entry read is 0x55.
REQ-040 Assert reset during bit 4 of 0xF0 -> all outputs at reset values; next frame 0x0F is received correctly.

Source files
------------

// File: rtl/receiver_controller.sv
// receiver_controller: UART receiver with 16x oversampling, selectable baud
// rate, a 4-byte first-word-fall-through receive FIFO and sticky error flags.
//
// state    | meaning
// ---------|----------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx to go low
// ST_START | qualifying start bit, checked at mid-bit (8th tick)
// ST_DATA  | sampling 8 data bits LSB-first, one every 16 ticks
// ST_STOP  | checking stop bit at the 16th tick
// ST_BREAK | stop bit was low; waiting for line to return high
`timescale 1ns/1ps
module receiver_controller #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_in,
  input  logic [1:0] S,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic [2:0] rx_count,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV_00_RAW = CLK_HZ / (9600 * 16);
  localparam int DIV_01_RAW = CLK_HZ / (19200 * 16);
  localparam int DIV_10_RAW = CLK_HZ / (57600 * 16);
  localparam int DIV_11_RAW = CLK_HZ / (115200 * 16);
  localparam int DIV_00 = (DIV_00_RAW < 1) ? 1 : DIV_00_RAW;
  localparam int DIV_01 = (DIV_01_RAW < 1) ? 1 : DIV_01_RAW;
  localparam int DIV_10 = (DIV_10_RAW < 1) ? 1 : DIV_10_RAW;
  localparam int DIV_11 = (DIV_11_RAW < 1) ? 1 : DIV_11_RAW;
  // The slowest baud needs the widest counter.
  localparam int CNT_W  = $clog2(DIV_00 + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               sync_ff1, rx;
  logic [1:0]         s_lat;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic [3:0]         sample_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;

  logic               start_frame, mid_start, bit_end, push_req, frame_set;

  logic [7:0]         mem [4];
  logic [1:0]         wr_ptr, rd_ptr, rd_next;
  logic [2:0]         count, count_d;
  logic               pop, full, wr_ok, overrun_set;
  logic [7:0]         head_d;

  // Tick reload value for a given baud select.
  function automatic logic [CNT_W-1:0] div_load(input logic [1:0] sel);
    case (sel)
      2'b00:   div_load = CNT_W'(DIV_00 - 1);
      2'b01:   div_load = CNT_W'(DIV_01 - 1);
      2'b10:   div_load = CNT_W'(DIV_10 - 1);
      default: div_load = CNT_W'(DIV_11 - 1);
    endcase
  endfunction

  // Two-flop synchronizer on the serial line, idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff1 <= 1'b1;
      rx       <= 1'b1;
    end else begin
      sync_ff1 <= ser_in;
      rx       <= sync_ff1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx) state_d = ST_START;
      ST_START: if (mid_start) state_d = rx ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_end && bit_idx == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (bit_end) state_d = rx ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and per-cycle strobes.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    tick        = (state_q != ST_IDLE) && (tick_cnt == '0);
    start_frame = (state_q == ST_IDLE) && !rx;
    mid_start   = (state_q == ST_START) && tick && (sample_cnt == 4'd7);
    bit_end     = tick && (sample_cnt == 4'd15);
    push_req    = (state_q == ST_STOP) && bit_end && rx;
    frame_set   = (state_q == ST_STOP) && bit_end && !rx;
  end

  // Baud tick down-counter, baud latch and bit sampling datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_lat      <= 2'b00;
      tick_cnt   <= '0;
      sample_cnt <= 4'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
    end else begin
      if (state_q == ST_IDLE) begin
        // Divider restarts as the frame begins, using the freshly latched rate.
        tick_cnt <= start_frame ? div_load(S) : '0;
      end else if (tick_cnt == '0) begin
        tick_cnt <= div_load(s_lat);
      end else begin
        tick_cnt <= tick_cnt - 1'b1;
      end

      if (start_frame) s_lat <= S;

      if (start_frame || mid_start) sample_cnt <= 4'd0;
      else if (tick)                sample_cnt <= sample_cnt + 4'd1;

      if (mid_start) bit_idx <= 3'd0;
      else if (state_q == ST_DATA && bit_end) bit_idx <= bit_idx + 3'd1;

      if (state_q == ST_DATA && bit_end) shreg <= {rx, shreg[7:1]};
    end
  end

  // FIFO pointer, occupancy and next-head computation.
  always_comb begin
    pop         = rd_en && (count != 3'd0);
    full        = (count == 3'(FIFO_DEPTH));
    wr_ok       = push_req && (!full || pop);
    overrun_set = push_req && full && !pop;
    count_d     = count + {2'b00, wr_ok} - {2'b00, pop};
    rd_next     = pop ? rd_ptr + 2'd1 : rd_ptr;
    head_d      = data_out;
    if (count_d != 3'd0) begin
      if (wr_ok && wr_ptr == rd_next) head_d = shreg;
      else                            head_d = mem[rd_next];
    end
  end

  // FIFO storage, pointers and registered fall-through head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      data_out <= 8'h00;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      rd_ptr   <= rd_next;
      count    <= count_d;
      data_out <= head_d;
    end
  end

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (overrun_set)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  assign rx_valid = (count != 3'd0);
  assign rx_count = count;

endmodule

// File: tb/tb_receiver_controller.sv
// tb_receiver_controller: directed UART frames with a byte scoreboard; a
// monitor compares every FIFO pop against the queued expected bytes.
`timescale 1ns/1ps
module tb_receiver_controller;

  localparam int CLK_HZ = 1_843_200;

  logic       clk = 1'b0;
  logic       reset;
  logic       ser_in;
  logic [1:0] S;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] data_out;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];

  receiver_controller #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ser_in(ser_in), .S(S), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(data_out), .rx_valid(rx_valid),
    .rx_count(rx_count), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT will take is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset && rd_en && rx_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got %02h, expected no data", data_out);
      end else begin
        check("pop_data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input logic v, input int div);
    ser_in = v;
    step(16 * div);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int div);
    step(1);
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(b[i], div);
    drive_bit(stop, div);
    ser_in = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ser_in = 1'b1; S = 2'b11; rd_en = 1'b0; clr_err = 1'b0;
    step(3);
    reset = 1'b0;
    step(4);
    check("rst_data_out",  {24'h0, data_out}, 32'h00);
    check("rst_rx_valid",  {31'h0, rx_valid}, 32'h0);
    check("rst_rx_count",  {29'h0, rx_count}, 32'h0);
    check("rst_busy",      {31'h0, busy},     32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun",   {31'h0, overrun},  32'h0);

    // 0xA5 at 115200; S changed mid-frame must not disturb it.
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1, 1);
      begin step(60); S = 2'b00; end
    join
    S = 2'b11;
    step(4);
    check("a5_rx_valid",  {31'h0, rx_valid},  32'h1);
    check("a5_rx_count",  {29'h0, rx_count},  32'h1);
    check("a5_data_out",  {24'h0, data_out},  32'hA5);
    check("a5_frame_err", {31'h0, frame_err}, 32'h0);
    pop_one();
    step(1);
    check("a5_empty",     {29'h0, rx_count},  32'h0);
    check("a5_hold",      {24'h0, data_out},  32'hA5);

    // Short low glitch: START entered, rejected at mid-bit.
    ser_in = 1'b0;
    step(4);
    check("glitch_busy",  {31'h0, busy}, 32'h1);
    step(2);
    ser_in = 1'b1;
    step(30);
    check("glitch_idle",     {31'h0, busy},      32'h0);
    check("glitch_rx_valid", {31'h0, rx_valid},  32'h0);
    check("glitch_fe",       {31'h0, frame_err}, 32'h0);
    check("glitch_ov",       {31'h0, overrun},   32'h0);

    // 0x3C at 19200 with low stop bit -> framing error, BREAK, then clear.
    S = 2'b01;
    send_byte(8'h3C, 1'b0, 6);
    step(10);
    check("fe_set",      {31'h0, frame_err}, 32'h1);
    check("fe_count",    {29'h0, rx_count},  32'h0);
    check("fe_idle",     {31'h0, busy},      32'h0);
    pulse_clr();
    check("fe_cleared",  {31'h0, frame_err}, 32'h0);

    // Five bytes with no reads: fifth dropped, overrun set.
    S = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1);
    end
    step(4);
    check("ov_count", {29'h0, rx_count}, 32'h4);
    check("ov_flag",  {31'h0, overrun},  32'h1);
    for (int i = 0; i < 4; i++) pop_one();
    check("ov_drained", {29'h0, rx_count}, 32'h0);
    pulse_clr();
    check("ov_cleared", {31'h0, overrun}, 32'h0);

    // Fill, then pop on the exact push cycle of 0x55 (push edge is the
    // 155th edge after the start bit is driven).
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i), 1'b1, 1);
    end
    exp_q.push_back(8'h55);
    fork
      send_byte(8'h55, 1'b1, 1);
      begin step(155); rd_en = 1'b1; step(1); rd_en = 1'b0; end
    join
    step(2);
    check("full_pp_count",   {29'h0, rx_count}, 32'h4);
    check("full_pp_overrun", {31'h0, overrun},  32'h0);
    for (int i = 0; i < 4; i++) pop_one();
    check("full_pp_hold", {24'h0, data_out}, 32'h55);

    // Reset during bit 4 of 0xF0, then a clean 0x0F.
    fork
      send_byte(8'hF0, 1'b1, 1);
      begin
        step(89);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_data_out", {24'h0, data_out},  32'h00);
        check("mid_rst_valid",    {31'h0, rx_valid},  32'h0);
        check("mid_rst_count",    {29'h0, rx_count},  32'h0);
        check("mid_rst_busy",     {31'h0, busy},      32'h0);
        check("mid_rst_fe",       {31'h0, frame_err}, 32'h0);
        check("mid_rst_ov",       {31'h0, overrun},   32'h0);
        step(2);
        reset = 1'b0;
      end
    join
    step(4);
    check("post_rst_count", {29'h0, rx_count}, 32'h0);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, 1);
    step(4);
    check("post_rst_valid", {31'h0, rx_valid}, 32'h1);
    check("post_rst_data",  {24'h0, data_out}, 32'h0F);
    pop_one();
    step(2);
    check("sb_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
